// File: rtl/gaussian_dsm_writer.sv
// DSM status writer: snapshots AFU status into one 64B line, writes it to the host DSM
// over c1 and waits for the tagged write response.
module gaussian_dsm_writer #(
   parameter int          ADDR_WIDTH  = 42,
   parameter int          STATE_WIDTH = 8,
   parameter logic [15:0] MDATA_TAG   = 16'hD5A0,
   parameter int          RSP_TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  dsm_base,
   input  logic                   status_req,
   input  logic                   run_start,
   input  logic                   run_active,
   input  logic [63:0]            c0tx_cnt,
   input  logic [63:0]            c1tx_cnt,
   input  logic [STATE_WIDTH-1:0] rd_state,
   input  logic [STATE_WIDTH-1:0] wr_state,
   output logic                   c1tx_valid,
   output logic [ADDR_WIDTH-1:0]  c1tx_addr,
   output logic [511:0]           c1tx_data,
   output logic [15:0]            c1tx_mdata,
   input  logic                   c1tx_almfull,
   input  logic                   c1rx_wrrsp_valid,
   input  logic [15:0]            c1rx_mdata,
   output logic                   busy,
   output logic                   status_done,
   output logic                   dsm_err
);

   // state    | meaning
   // IDLE     | waiting for status_req or a pending request
   // ISSUE    | snapshot captured, waiting for c1 almost-full to drop
   // WAIT_RSP | write sent, waiting for the tagged response or timeout
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

   localparam int TW = $clog2(RSP_TIMEOUT + 1);

   state_t        state;
   logic [31:0]   seq;
   logic [63:0]   run_cycles;
   logic          pending;
   logic [TW-1:0] timer;
   logic [511:0]  line;

   always_comb begin
      line          = '0;
      line[0]       = 1'b1;
      line[63:32]   = seq + 32'd1;
      line[127:64]  = c0tx_cnt;
      line[191:128] = c1tx_cnt;
      line[255:192] = 64'(rd_state);
      line[319:256] = 64'(wr_state);
      line[383:320] = run_cycles;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         seq         <= '0;
         run_cycles  <= '0;
         pending     <= 1'b0;
         timer       <= '0;
         c1tx_valid  <= 1'b0;
         c1tx_addr   <= '0;
         c1tx_data   <= '0;
         c1tx_mdata  <= '0;
         busy        <= 1'b0;
         status_done <= 1'b0;
         dsm_err     <= 1'b0;
      end else begin
         if (run_start)
            run_cycles <= '0;
         else if (run_active)
            run_cycles <= run_cycles + 64'd1;

         c1tx_valid  <= 1'b0;
         status_done <= 1'b0;
         if (status_req && state != IDLE)
            pending <= 1'b1;

         case (state)
            IDLE: begin
               if (status_req || pending) begin
                  pending <= 1'b0;
                  if (dsm_base == '0) begin
                     dsm_err <= 1'b1;
                  end else begin
                     c1tx_addr  <= dsm_base;
                     c1tx_data  <= line;
                     c1tx_mdata <= MDATA_TAG;
                     busy       <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (!c1tx_almfull) begin
                  c1tx_valid <= 1'b1;
                  timer      <= TW'(RSP_TIMEOUT - 1);
                  state      <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (c1rx_wrrsp_valid && c1rx_mdata == MDATA_TAG) begin
                  seq         <= seq + 32'd1;
                  status_done <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (timer == '0) begin
                  dsm_err <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gaussian_dsm_writer.sv
// Directed bench for gaussian_dsm_writer: hand-computed status lines, handshake timing,
// back-pressure, request coalescing, missing base, response timeout and reset abort.
module tb_gaussian_dsm_writer;

   logic         clk = 1'b0;
   logic         reset;
   logic [41:0]  dsm_base;
   logic         status_req, run_start, run_active;
   logic [63:0]  c0tx_cnt, c1tx_cnt;
   logic [7:0]   rd_state, wr_state;
   logic         c1tx_valid;
   logic [41:0]  c1tx_addr;
   logic [511:0] c1tx_data;
   logic [15:0]  c1tx_mdata;
   logic         c1tx_almfull, c1rx_wrrsp_valid;
   logic [15:0]  c1rx_mdata;
   logic         busy, status_done, dsm_err;

   int checks = 0;
   int errors = 0;
   int beats  = 0;
   int base_beats;
   int wait_cycles;

   gaussian_dsm_writer dut (
      .clk(clk), .reset(reset), .dsm_base(dsm_base), .status_req(status_req),
      .run_start(run_start), .run_active(run_active), .c0tx_cnt(c0tx_cnt),
      .c1tx_cnt(c1tx_cnt), .rd_state(rd_state), .wr_state(wr_state),
      .c1tx_valid(c1tx_valid), .c1tx_addr(c1tx_addr), .c1tx_data(c1tx_data),
      .c1tx_mdata(c1tx_mdata), .c1tx_almfull(c1tx_almfull),
      .c1rx_wrrsp_valid(c1rx_wrrsp_valid), .c1rx_mdata(c1rx_mdata),
      .busy(busy), .status_done(status_done), .dsm_err(dsm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (c1tx_valid) beats++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_req();
      status_req = 1'b1;
      tick();
      status_req = 1'b0;
   endtask

   task automatic rsp(input logic [15:0] m);
      c1rx_wrrsp_valid = 1'b1;
      c1rx_mdata       = m;
      tick();
      c1rx_wrrsp_valid = 1'b0;
      c1rx_mdata       = '0;
   endtask

   initial begin
      reset = 1'b1; dsm_base = '0; status_req = 1'b0; run_start = 1'b0; run_active = 1'b0;
      c0tx_cnt = '0; c1tx_cnt = '0; rd_state = '0; wr_state = '0;
      c1tx_almfull = 1'b0; c1rx_wrrsp_valid = 1'b0; c1rx_mdata = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", 64'(c1tx_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(dsm_err), 64'd0);
      chk("rst_data", c1tx_data[63:0], 64'd0);

      // basic write: status_req -> valid two cycles later
      dsm_base = 42'h1000; c0tx_cnt = 64'd5; c1tx_cnt = 64'd7; rd_state = 8'd3; wr_state = 8'd4;
      base_beats = beats;
      pulse_req();
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_valid_early", 64'(c1tx_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(c1tx_valid), 64'd1);
      chk("t1_addr", 64'(c1tx_addr), 64'h1000);
      chk("t1_mdata", 64'(c1tx_mdata), 64'hD5A0);
      chk("t1_w0", c1tx_data[63:0], 64'h1_0000_0001);
      chk("t1_c0", c1tx_data[127:64], 64'd5);
      chk("t1_c1", c1tx_data[191:128], 64'd7);
      chk("t1_rd", c1tx_data[255:192], 64'd3);
      chk("t1_wr", c1tx_data[319:256], 64'd4);
      chk("t1_hi", c1tx_data[511:448], 64'd0);
      tick();
      chk("t1_valid_1cyc", 64'(c1tx_valid), 64'd0);
      rsp(16'h1234);
      chk("t1_wrong_tag_busy", 64'(busy), 64'd1);
      chk("t1_wrong_tag_done", 64'(status_done), 64'd0);
      rsp(16'hD5A0);
      chk("t1_done", 64'(status_done), 64'd1);
      chk("t1_busy_clr", 64'(busy), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(status_done), 64'd0);
      chk("t1_addr_hold", 64'(c1tx_addr), 64'h1000);
      chk("t1_beats", 64'(beats - base_beats), 64'd1);

      // run cycle counter: 3 increments, run_start wins, then 5 increments
      run_active = 1'b1;
      tick(); tick(); tick();
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      run_active = 1'b0;
      pulse_req();
      tick();
      chk("rc_valid", 64'(c1tx_valid), 64'd1);
      chk("rc_run", c1tx_data[383:320], 64'd5);
      chk("rc_seq", 64'(c1tx_data[63:32]), 64'd2);
      rsp(16'hD5A0);
      chk("rc_done", 64'(status_done), 64'd1);

      // back-pressure: almfull high for 10 cycles, snapshot frozen
      do_reset();
      c0tx_cnt = 64'd5;
      c1tx_almfull = 1'b1;
      base_beats = beats;
      pulse_req();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) c0tx_cnt = 64'd9;
         tick();
      end
      chk("af_no_beat", 64'(beats - base_beats), 64'd0);
      chk("af_busy", 64'(busy), 64'd1);
      c1tx_almfull = 1'b0;
      tick();
      chk("af_valid", 64'(c1tx_valid), 64'd1);
      chk("af_c0_snapshot", c1tx_data[127:64], 64'd5);
      rsp(16'hD5A0);
      tick();
      chk("af_one_beat", 64'(beats - base_beats), 64'd1);

      // three requests during WAIT_RSP coalesce into one more write
      do_reset();
      base_beats = beats;
      pulse_req();
      tick();
      for (int i = 0; i < 3; i++) begin
         pulse_req();
         tick();
      end
      rsp(16'hD5A0);
      chk("co_done", 64'(status_done), 64'd1);
      tick();
      chk("co_busy_again", 64'(busy), 64'd1);
      tick();
      chk("co_valid2", 64'(c1tx_valid), 64'd1);
      chk("co_seq2", 64'(c1tx_data[63:32]), 64'd2);
      rsp(16'hD5A0);
      tick(); tick(); tick();
      chk("co_beats", 64'(beats - base_beats), 64'd2);
      chk("co_idle", 64'(busy), 64'd0);

      // no DSM base programmed
      do_reset();
      dsm_base = '0;
      base_beats = beats;
      pulse_req();
      chk("nb_err", 64'(dsm_err), 64'd1);
      chk("nb_busy", 64'(busy), 64'd0);
      tick(); tick(); tick();
      chk("nb_no_beat", 64'(beats - base_beats), 64'd0);
      chk("nb_err_sticky", 64'(dsm_err), 64'd1);

      // response timeout after 4096 cycles in WAIT_RSP
      do_reset();
      dsm_base = 42'h2000;
      pulse_req();
      tick();
      chk("to_valid", 64'(c1tx_valid), 64'd1);
      wait_cycles = 0;
      while (busy && wait_cycles < 5000) begin
         tick();
         wait_cycles++;
      end
      chk("to_cycles", 64'(wait_cycles), 64'd4096);
      chk("to_err", 64'(dsm_err), 64'd1);
      pulse_req();
      tick();
      chk("to_next_valid", 64'(c1tx_valid), 64'd1);
      chk("to_next_seq", 64'(c1tx_data[63:32]), 64'd1);
      chk("to_next_addr", 64'(c1tx_addr), 64'h2000);
      rsp(16'hD5A0);
      chk("to_err_sticky", 64'(dsm_err), 64'd1);

      // reset during WAIT_RSP, then a late response
      do_reset();
      pulse_req();
      tick();
      do_reset();
      chk("ra_valid", 64'(c1tx_valid), 64'd0);
      chk("ra_addr", 64'(c1tx_addr), 64'd0);
      chk("ra_busy", 64'(busy), 64'd0);
      rsp(16'hD5A0);
      chk("ra_no_done", 64'(status_done), 64'd0);
      chk("ra_data", c1tx_data[63:0], 64'd0);
      pulse_req();
      tick();
      chk("ra_seq", 64'(c1tx_data[63:32]), 64'd1);
      rsp(16'hD5A0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
